// File: rtl/fifo_arb_pkg.sv
// Shared helpers for the arbitrated FIFO controller: round-robin pick and
// rotation-pointer width.
package fifo_arb_pkg;

   localparam int unsigned MAX_NREQ = 8;

   function automatic int unsigned rr_ptr_width(input int unsigned nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   // Walk offsets from farthest to nearest so the nearest asserted request wins.
   function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] req,
                                           input int unsigned ptr,
                                           input int unsigned nreq);
      logic [2:0] idx;
      int unsigned pick;
      pick = ptr;
      for (int unsigned o = nreq; o > 0; o--) begin
         idx = 3'((ptr + o - 1) % nreq);
         if (req[idx]) pick = 32'(idx);
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from ptr, plus the
// rotation pointer to use after a grant.
module rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   localparam int unsigned PW  = rr_ptr_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   next_ptr
);

   logic [MAX_NREQ-1:0] req_ext;
   logic [PW-1:0]       pick;

   always_comb begin
      req_ext             = '0;
      req_ext[NREQ-1:0]   = req;
      pick                = PW'(rr_pick(req_ext, 32'(ptr), NREQ));
      grant               = '0;
      if (|req) grant[pick] = 1'b1;
      next_ptr            = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
   end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Shared-fifomem controller: round-robin write arbitration, pointers, count/flags.
// Optional stall counter enabled by defining FIFO_ARB_OVF_CNT_EN.
module fifo_arb_ctrl
   import fifo_arb_pkg::*;
#(
   parameter int unsigned DATASIZE = 8,
   parameter int unsigned ADDRSIZE = 4,
   parameter int unsigned NREQ     = 4,
   parameter int unsigned AF_LEVEL = 12
) (
   input  logic                     wclk,
   input  logic                     wrst,
   input  logic                     flush,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DATASIZE-1:0] req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [DATASIZE-1:0]      rd_data,
   output logic [ADDRSIZE-1:0]      count,
   output logic                     full,
   output logic                     almost_full,
   output logic [15:0]              ovf_cnt,
   output logic [ADDRSIZE-1:0]      mem_waddr,
   output logic [ADDRSIZE-1:0]      mem_raddr,
   output logic [DATASIZE-1:0]      mem_wdata,
   output logic                     mem_wclken,
   output logic                     mem_wfull,
   input  logic [DATASIZE-1:0]      mem_rdata
);

   localparam int unsigned PW = rr_ptr_width(NREQ);
   localparam logic [ADDRSIZE-1:0] CNT_MAX = '1;

   logic [ADDRSIZE-1:0] wptr, rptr, count_next;
   logic [PW-1:0]       rr_ptr, rr_next;
   logic [NREQ-1:0]     req_elig;
   logic                wr, rd;

   // Reset gates the grant combinationally so req_ready drops with wrst.
   assign req_elig = req_valid & {NREQ{~full & ~flush & ~wrst}};

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req      (req_elig),
      .ptr      (rr_ptr),
      .grant    (req_ready),
      .next_ptr (rr_next)
   );

   assign wr         = |req_ready;
   assign rd         = rd_en & rd_valid & ~flush;
   assign rd_valid   = (count != '0);
   assign rd_data    = mem_rdata;
   assign mem_waddr  = wptr;
   assign mem_raddr  = rptr;
   assign mem_wclken = wr;
   assign mem_wfull  = 1'b0;

   always_comb begin
      mem_wdata = '0;
      for (int unsigned i = 0; i < NREQ; i++)
         if (req_ready[i]) mem_wdata = req_data[i*DATASIZE +: DATASIZE];
   end

   always_comb begin
      count_next = count;
      if (flush)          count_next = '0;
      else if (wr && !rd) count_next = count + 1'b1;
      else if (!wr && rd) count_next = count - 1'b1;
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         rr_ptr      <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         count       <= count_next;
         full        <= (count_next == CNT_MAX);
         almost_full <= (32'(count_next) >= AF_LEVEL);
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
         end
         if (wr) rr_ptr <= rr_next;
      end
   end

`ifdef FIFO_ARB_OVF_CNT_EN
   logic [15:0] ovf_q;

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst)
         ovf_q <= '0;
      else if (flush)
         ovf_q <= '0;
      else if ((|req_valid) && full && (ovf_q != '1))
         ovf_q <= ovf_q + 1'b1;
   end

   assign ovf_cnt = ovf_q;
`else
   assign ovf_cnt = '0;
`endif

endmodule
